// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point alignment datapath.
// Holds IEEE-754 single-precision field widths, the Inf/NaN exponent code,
// the unpacked operand type and small unpack helpers used by fp_align.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  // {hidden, frac, G, R, S}
  localparam int unsigned MANT_W = 27;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;   // raw biased exponent field
    logic [FRAC_W:0]   mant;  // {hidden, frac}
  } fp_unpacked_t;

  // Split a raw single-precision word; the hidden bit is clear for zero/denormals.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.mant = {(x[30:23] != '0), x[22:0]};
    return u;
  endfunction

  // Denormals share the scale of exponent 1.
  function automatic logic [EXP_W-1:0] fp_eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Right shifter for the smaller mantissa.
// Ports:
//   din   [26:0] mantissa {data, G, R, S} before alignment
//   shamt [7:0]  exponent difference; 27 or more clears data, G and R
//   dout  [26:0] aligned mantissa; bit 0 is the sticky bit
// Macro FP_ALIGN_STICKY_EN: when defined, the sticky bit is the OR of every
// bit shifted out; otherwise the sticky bit is 0 and no reduction is built.
module fp_rshift_sticky
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] din,
  input  logic [EXP_W-1:0]  shamt,
  output logic [MANT_W-1:0] dout
);

  logic [MANT_W-1:0] shifted;

  always_comb begin
    shifted = '0;
    if (shamt < EXP_W'(MANT_W)) begin
      shifted = din >> shamt;
    end
  end

`ifdef FP_ALIGN_STICKY_EN
  logic [2*MANT_W-1:0] ext;
  logic                lost;

  // The low half of ext collects exactly the bits that fall off the bottom.
  always_comb begin
    ext  = {din, {MANT_W{1'b0}}} >> shamt;
    lost = 1'b0;
    if (shamt < EXP_W'(MANT_W)) begin
      lost = |ext[MANT_W-1:0];
    end else begin
      lost = |din;
    end
  end

  assign dout = {shifted[MANT_W-1:1], shifted[0] | lost};
`else
  // Truncation: whatever lands in the S position is dropped.
  assign dout = shifted & ~MANT_W'(1);
`endif

endmodule

// File: rtl/fp_align.sv
// Two-stage exponent-alignment front end for a single-precision adder.
// Stage 1 unpacks a and b, orders them by magnitude and registers the
// exponent difference; stage 2 right-shifts the smaller mantissa.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for operand pair a, b [31:0]
//   out_valid/out_ready  output handshake
//   sign1, sign2         signs of a and b, unswapped
//   sel                  1 when |a| >= |b|
//   exp_big [7:0]        raw biased exponent of the larger operand
//   mant_big [26:0]      {hidden, frac, 3'b000} of the larger operand
//   mant_small [26:0]    aligned smaller mantissa {data, G, R, S}
//   special              either operand has exponent 8'hFF
// Macro FP_ALIGN_STICKY_EN selects the sticky-bit computation in the shifter.
module fp_align
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign1,
  output logic              sign2,
  output logic              sel,
  output logic [EXP_W-1:0]  exp_big,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              special
);

  // Stage 1 combinational unpack and ordering.
  fp_unpacked_t     ua, ub;
  logic             a_ge_b;
  logic [EXP_W-1:0] big_exp, small_exp, diff;
  logic [FRAC_W:0]  big_mant, small_mant;
  logic             in_special;

  always_comb begin
    ua         = fp_unpack(a);
    ub         = fp_unpack(b);
    // {exp, frac} as an unsigned integer orders magnitudes directly.
    a_ge_b     = ({ua.exp, ua.mant[FRAC_W-1:0]} >= {ub.exp, ub.mant[FRAC_W-1:0]});
    big_exp    = a_ge_b ? ua.exp  : ub.exp;
    small_exp  = a_ge_b ? ub.exp  : ua.exp;
    big_mant   = a_ge_b ? ua.mant : ub.mant;
    small_mant = a_ge_b ? ub.mant : ua.mant;
    diff       = fp_eff_exp(big_exp) - fp_eff_exp(small_exp);
    in_special = (ua.exp == EXP_MAX) || (ub.exp == EXP_MAX);
  end

  // Stage 1 registers.
  logic             s1_valid_q;
  logic             s1_sign1_q, s1_sign2_q, s1_sel_q, s1_special_q;
  logic [EXP_W-1:0] s1_exp_big_q, s1_diff_q;
  logic [FRAC_W:0]  s1_mant_big_q, s1_mant_small_q;

  // Stage 2 (output) registers.
  logic              out_valid_q;
  logic              sign1_q, sign2_q, sel_q, special_q;
  logic [EXP_W-1:0]  exp_big_q;
  logic [MANT_W-1:0] mant_big_q, mant_small_q;

  // Handshake: a stage advances when empty or when its successor advances.
  logic s2_ready, s1_advance, in_accept;

  always_comb begin
    s2_ready   = !out_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_ready;
    in_ready   = !s1_valid_q || s1_advance;
    in_accept  = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q      <= 1'b0;
      s1_sign1_q      <= 1'b0;
      s1_sign2_q      <= 1'b0;
      s1_sel_q        <= 1'b0;
      s1_special_q    <= 1'b0;
      s1_exp_big_q    <= '0;
      s1_diff_q       <= '0;
      s1_mant_big_q   <= '0;
      s1_mant_small_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_accept) begin
        s1_sign1_q      <= ua.sign;
        s1_sign2_q      <= ub.sign;
        s1_sel_q        <= a_ge_b;
        s1_special_q    <= in_special;
        s1_exp_big_q    <= big_exp;
        s1_diff_q       <= diff;
        s1_mant_big_q   <= big_mant;
        s1_mant_small_q <= small_mant;
      end
    end
  end

  logic [MANT_W-1:0] small_aligned;

  fp_rshift_sticky u_rshift (
    .din   ({s1_mant_small_q, 3'b000}),
    .shamt (s1_diff_q),
    .dout  (small_aligned)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      sel_q        <= 1'b0;
      special_q    <= 1'b0;
      exp_big_q    <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
    end else begin
      if (s2_ready) begin
        out_valid_q <= s1_valid_q;
      end
      // Data only moves with a real beat so a stalled output stays put.
      if (s1_advance) begin
        sign1_q      <= s1_sign1_q;
        sign2_q      <= s1_sign2_q;
        sel_q        <= s1_sel_q;
        special_q    <= s1_special_q;
        exp_big_q    <= s1_exp_big_q;
        mant_big_q   <= {s1_mant_big_q, 3'b000};
        mant_small_q <= small_aligned;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign sign1      = sign1_q;
  assign sign2      = sign2_q;
  assign sel        = sel_q;
  assign special    = special_q;
  assign exp_big    = exp_big_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;

endmodule

// File: tb/tb_fp_align.sv
// Self-checking bench for fp_align: directed cases plus randomized operand
// pairs and randomized downstream back-pressure, checked against a
// behavioural alignment model and an in-order scoreboard.
module tb_fp_align;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic        sign1, sign2, sel, special;
  logic [7:0]  exp_big;
  logic [26:0] mant_big, mant_small;

  fp_align dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign1      (sign1),
    .sign2      (sign2),
    .sel        (sel),
    .exp_big    (exp_big),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .special    (special)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Back-pressure: forced level or a random bit refreshed away from edges.
  logic rand_mode   = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_ready   = 1'b1;
  always @(posedge clk) begin
    #2;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end
  assign out_ready = rand_mode ? rnd_ready : ready_force;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic [65:0] exp_q[$];

  wire [66:0] cur = {out_valid, sign1, sign2, sel, exp_big, mant_big, mant_small, special};

  task automatic chk(input string tag, input logic [66:0] got, input logic [66:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Alignment computed from the numeric meaning of the fields.
  function automatic logic [65:0] model(input logic [31:0] x, input logic [31:0] y);
    longint unsigned ex, ey, mx, my, mb, ms, shifted, lost_mask;
    longint unsigned eb, es, d;
    bit x_big, s, lost;
    ex = longint'(x[30:23]);
    ey = longint'(y[30:23]);
    mx = (((ex == 0) ? 0 : 64'h80_0000) + longint'(x[22:0])) * 8;
    my = (((ey == 0) ? 0 : 64'h80_0000) + longint'(y[22:0])) * 8;
    x_big = (longint'(x[30:0]) >= longint'(y[30:0]));
    eb = x_big ? ex : ey;
    es = x_big ? ey : ex;
    mb = x_big ? mx : my;
    ms = x_big ? my : mx;
    d  = ((eb == 0) ? 1 : eb) - ((es == 0) ? 1 : es);
    if (d >= 27) begin
      shifted = 0;
      lost    = (ms != 0);
    end else begin
      shifted   = ms >> d;
      lost_mask = (64'd1 << d) - 1;
      lost      = ((ms & lost_mask) != 0);
    end
    s = STICKY && (shifted[0] || lost);
    return {x[31], y[31], x_big, 8'(eb), 27'(mb), 27'((shifted & ~64'd1) | longint'(s)),
            (ex == 255) || (ey == 255)};
  endfunction

  // Output monitor: in-order scoreboard plus stall stability.
  logic        held = 1'b0;
  logic [66:0] held_val;
  always @(negedge clk) begin
    if (rstn) begin
      if (held) chk("stall_stable", cur, held_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h want none", cur);
        end else begin
          chk("beat", cur, {1'b1, exp_q.pop_front()});
        end
      end
      held     = out_valid && !out_ready;
      held_val = cur;
    end else begin
      held = 1'b0;
    end
  end

  // Present a pair and hold it until accepted; called just after a rising edge.
  task automatic push(input logic [31:0] x, input logic [31:0] y);
    bit rdy, done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(model(x, y));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 67'(exp_q.size()), 67'd0);
  endtask

  function automatic logic [31:0] gen_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[30:23] = 8'd0;
      1: r[30:23] = 8'(112 + $urandom_range(0, 30));
      2: r[30:23] = 8'hFF;
      3: r[30:23] = 8'(127 + $urandom_range(0, 1));
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    rstn     = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #2;
    chk("reset_outputs", cur, 67'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("reset_in_ready", 67'(in_ready), 67'd1);

    // 1.0 vs 1.5: b larger, two-cycle latency.
    @(posedge clk);
    #1;
    push(32'h3F80_0000, 32'h3FC0_0000);
    chk("lat_not_yet", 67'(out_valid), 67'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 67'(out_valid), 67'd1);
    chk("r032_fields", {sel, exp_big, mant_big, mant_small, special},
        {1'b0, 8'h7F, 27'h600_0000, 27'h400_0000, 1'b0});
    drain();

    // Shift of 32: everything falls into the sticky position.
    push(32'h4F80_0000, 32'h3F80_0000);
    @(posedge clk);
    #1;
    chk("r033_sel", 67'(sel), 67'd1);
    chk("r033_small", 67'(mant_small), STICKY ? 67'd1 : 67'd0);
    drain();

    // Denormal vs smallest normal: same effective exponent.
    push(32'h0000_0001, 32'h0080_0000);
    @(posedge clk);
    #1;
    chk("r035_fields", {sel, exp_big, mant_small}, {1'b0, 8'h01, 27'h000_0008});
    drain();

    // Equal magnitudes choose a, infinity flags special.
    push(32'h4000_0000, 32'hC000_0000);
    @(posedge clk);
    #1;
    chk("equal_sel", 67'(sel), 67'd1);
    drain();
    push(32'h7F80_0000, 32'h3F80_0000);
    @(posedge clk);
    #1;
    chk("r036_special", 67'(special), 67'd1);
    drain();

    // Stall: two accepts fill the pipe, the third waits.
    ready_force = 1'b0;
    push(32'h3F80_0000, 32'h4000_0000);
    push(32'h4040_0000, 32'h3F00_0000);
    in_valid = 1'b1;
    a        = 32'h4080_0000;
    b        = 32'h4100_0000;
    @(negedge clk);
    chk("stall_in_ready", 67'(in_ready), 67'd0);
    chk("stall_out_valid", 67'(out_valid), 67'd1);
    repeat (3) @(posedge clk);
    #1;
    ready_force = 1'b1;
    push(32'h4080_0000, 32'h4100_0000);
    drain();

    // Reset with two beats in flight: they must vanish.
    ready_force = 1'b0;
    push(32'h3F80_0000, 32'h3F80_0001);
    push(32'h4000_0000, 32'h0000_0010);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midreset_outputs", cur, 67'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn        = 1'b1;
    ready_force = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midreset_no_stale", 67'(out_valid), 67'd0);

    // Random pairs under random back-pressure and input gaps.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = gen_op();
      y = ($urandom_range(0, 5) == 0) ? (x ^ 32'(1 << $urandom_range(0, 5))) : gen_op();
      push(x, y);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  operand pair a/b presented.
REQ-004 in_ready  output  1  block accepts the pair this cycle.
REQ-005 a, b  input  32 each  IEEE-754 single-precision operands.
REQ-006 out_valid  output  1  aligned result presented.
REQ-007 out_ready  input  1  downstream (sign/mantissa stage) accepts the result.
REQ-008 sign1, sign2  output  1 each  registered signs of a and b, unswapped.
REQ-009 sel  output  1  1 iff |a| >= |b|, so the downstream sign stage takes sign1.
REQ-010 exp_big  output  8  biased exponent of the larger-magnitude operand.
REQ-011 mant_big  output  27  {hidden, frac[22:0], 3'b000} of the larger operand.
REQ-012 mant_small  output  27  smaller mantissa, right-shifted, {data, G, R, S}.
REQ-013 special  output  1  either operand has exponent 8'hFF (Inf/NaN).

Function
REQ-014 The block SHALL be a 2-stage pipeline with a latency of 2 accepted cycles from the in handshake to out_valid.
REQ-015 Stage 1 SHALL unpack both operands. If exp==0, the hidden bit SHALL be 0 and the effective exponent 1; otherwise the hidden bit SHALL be 1.
REQ-016 Stage 1 SHALL compare {exp, frac} of a and b, set sel, swap operands so "big" is the larger one, and register diff = eff_exp_big - eff_exp_small as 8 bits unsigned.
REQ-017 Stage 2 SHALL right-shift the 27-bit small mantissa by diff. A shift of 27 or more SHALL give data=0, G=0, R=0.
REQ-018 The S bit SHALL be the OR of every bit shifted out below R (see REQ-028).
REQ-019 Equal magnitudes SHALL give sel=1 and diff=0.
REQ-020 special SHALL be computed from the raw exponents. The mantissa fields remain computed normally.
REQ-021 A stage SHALL advance when it is empty or when its successor advances. Output: out_valid && out_ready.
REQ-022 in_ready SHALL equal !s1_valid || s1_advance and SHALL be combinationally independent of in_valid.
REQ-023 While out_valid=1 and out_ready=0, every output SHALL remain stable; no beat SHALL be lost or duplicated.
REQ-024 Simultaneous accept and emit in the same cycle SHALL sustain a throughput of 1 pair per cycle.

Reset
REQ-025 On rstn low, all valids, sign1, sign2, sel, exp_big, mant_big, mant_small and special SHALL go to 0 immediately. in_ready SHALL be 1 once rstn is high.
REQ-026 Reset mid-operation SHALL discard all in-flight beats. No output SHALL appear for them after release.

Configuration
REQ-027 The macro FP_ALIGN_STICKY_EN SHALL select how the S bit is computed.
REQ-028 With FP_ALIGN_STICKY_EN defined, S SHALL be the OR-reduction of all shifted-out bits.
REQ-029 Without FP_ALIGN_STICKY_EN, S SHALL be tied to 0 (truncation) and the reduction logic SHALL be absent.

Structure
REQ-030 A shared package fp_pkg SHALL hold: EXP_W=8, FRAC_W=23, MANT_W=27, EXP_MAX=8'hFF, and a typedef fp_unpacked_t {sign, exp, mant}.
REQ-031 The shifter SHALL be a sub-module fp_rshift_sticky (27-bit in, 8-bit shift, 27-bit out including sticky). It is instantiated once in stage 2.

Verification
REQ-032 a=0x3F800000, b=0x3FC00000 -> after 2 cycles: sel=0, exp_big=0x7F, mant_big=0x6000000, mant_small=0x4000000, special=0.
REQ-033 a=0x4F800000, b=0x3F800000 (diff 32) -> sel=1, mant_small=0x0000001 with the macro, 0x0000000 without it.
REQ-034 3 back-to-back pairs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; all 3 results then emerge in order with no loss.
REQ-035 a=0x00000001, b=0x00800000 -> sel=0, exp_big=0x01, diff 0, mant_small=0x0000008.
REQ-036 a=0x7F800000, b=0x3F800000 -> special=1. Separately, pulse rstn low with 2 beats in flight -> out_valid=0 and no stale output after release.
